audio_out_serializer: RTL and testbench

Transmit-side counterpart of the audio ADC input path. Buffers left and right PCM samples written by the host side, then shifts them MSB-first onto the codec DAC data line in left-justified format. Uses the same codec clock-edge strobes (`bit_clk_*_edge`, `left_right_clk_*_edge`) and the same `done_channel_sync` qualifier as the input path. Sits between the audio controller's register/streaming interface and the codec DACDAT pin.

---
 rtl/audio_out_pkg.sv | 14 +
 rtl/audio_out_sync_fifo.sv | 67 ++++++
 rtl/audio_out_serializer.sv | 185 ++++++++++++++++++
 tb/tb_audio_out_serializer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_out_pkg.sv
// Shared types and default sizing for the audio DAC output path.
package audio_out_pkg;

    localparam int DEFAULT_AUDIO_DATA_WIDTH = 32;
    localparam int DEFAULT_FIFO_DEPTH       = 128;
    localparam int DEFAULT_FIFO_ADDR_WIDTH  = 7;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LEFT_TX   = 2'd1,
        RIGHT_TX  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/audio_out_sync_fifo.sv
// Per-channel synchronous FIFO with a show-ahead head word.
// words_used wraps to 0 at full; callers use fifo_is_full to tell full from empty.
module audio_out_sync_fifo
    import audio_out_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_AUDIO_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    output logic                  fifo_is_empty,
    output logic                  fifo_is_full,
    output logic [ADDR_WIDTH-1:0] words_used,
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  push, pop;

    // Gate push on full and pop on empty; a simultaneous push+pop leaves the count unchanged.
    always_comb begin
        push     = write_en & ~count_q[ADDR_WIDTH];
        pop      = read_en & (count_q != '0);
        wr_ptr_d = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (ADDR_WIDTH+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (ADDR_WIDTH+1)'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy governs validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= write_data;
        end
    end

    assign read_data     = mem[rd_ptr_q];
    assign fifo_is_empty = (count_q == '0);
    assign fifo_is_full  = count_q[ADDR_WIDTH];
    assign words_used    = count_q[ADDR_WIDTH-1:0];

endmodule

// File: rtl/audio_out_serializer.sv
// Buffers left/right PCM samples and shifts them MSB-first onto DACDAT,
// left-justified, using the codec BCLK/LRCLK edge strobes.
// Optional macro AUDIO_OUT_UNDERRUN_HOLD_EN: on FIFO underrun repeat the last
// popped sample of that channel instead of sending silence.
module audio_out_serializer
    import audio_out_pkg::*;
#(
    parameter int AUDIO_DATA_WIDTH = DEFAULT_AUDIO_DATA_WIDTH,
    parameter int FIFO_DEPTH       = DEFAULT_FIFO_DEPTH,
    parameter int FIFO_ADDR_WIDTH  = DEFAULT_FIFO_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bit_clk_rising_edge,
    input  logic                        bit_clk_falling_edge,
    input  logic                        left_right_clk_rising_edge,
    input  logic                        left_right_clk_falling_edge,
    input  logic                        done_channel_sync,
    input  logic [AUDIO_DATA_WIDTH-1:0] left_channel_data,
    input  logic [AUDIO_DATA_WIDTH-1:0] right_channel_data,
    input  logic                        write_left_audio_data_en,
    input  logic                        write_right_audio_data_en,
    output logic [7:0]                  left_audio_fifo_write_space,
    output logic [7:0]                  right_audio_fifo_write_space,
    output logic                        serial_audio_out_data
);

    localparam int BITS_W = $clog2(AUDIO_DATA_WIDTH + 1);

    tx_state_t                   state_q, state_d;
    logic [AUDIO_DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BITS_W-1:0]           bits_q, bits_d;
    logic                        serial_q, serial_d;
    logic [7:0]                  left_space_q, left_space_d;
    logic [7:0]                  right_space_q, right_space_d;

    logic                        load, left_pop, right_pop;
    logic                        left_empty, left_full, right_empty, right_full;
    logic [FIFO_ADDR_WIDTH-1:0]  left_used, right_used;
    logic [AUDIO_DATA_WIDTH-1:0] left_head, right_head;
    logic [AUDIO_DATA_WIDTH-1:0] left_underrun, right_underrun;

    // DACDAT only changes on BCLK falling edges; the rising strobe is kept for port compatibility.
    logic unused_bit_clk_rising;
    assign unused_bit_clk_rising = bit_clk_rising_edge;

    audio_out_sync_fifo #(
        .DATA_WIDTH (AUDIO_DATA_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_left_fifo (
        .clk           (clk),
        .reset         (reset),
        .write_en      (write_left_audio_data_en),
        .write_data    (left_channel_data),
        .read_en       (left_pop),
        .fifo_is_empty (left_empty),
        .fifo_is_full  (left_full),
        .words_used    (left_used),
        .read_data     (left_head)
    );

    audio_out_sync_fifo #(
        .DATA_WIDTH (AUDIO_DATA_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_right_fifo (
        .clk           (clk),
        .reset         (reset),
        .write_en      (write_right_audio_data_en),
        .write_data    (right_channel_data),
        .read_en       (right_pop),
        .fifo_is_empty (right_empty),
        .fifo_is_full  (right_full),
        .words_used    (right_used),
        .read_data     (right_head)
    );

`ifdef AUDIO_OUT_UNDERRUN_HOLD_EN
    logic [AUDIO_DATA_WIDTH-1:0] left_last_q, left_last_d;
    logic [AUDIO_DATA_WIDTH-1:0] right_last_q, right_last_d;

    // Track the most recently popped sample per channel for underrun repeat.
    always_comb begin
        left_last_d  = left_pop  ? left_head  : left_last_q;
        right_last_d = right_pop ? right_head : right_last_q;
    end

    // Hold registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            left_last_q  <= '0;
            right_last_q <= '0;
        end else begin
            left_last_q  <= left_last_d;
            right_last_q <= right_last_d;
        end
    end

    assign left_underrun  = left_last_q;
    assign right_underrun = right_last_q;
`else
    assign left_underrun  = '0;
    assign right_underrun = '0;
`endif

    // Next-state, slot load/pop, shifter and registered-output computation.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bits_d    = bits_q;
        left_pop  = 1'b0;
        right_pop = 1'b0;

        // Both LRCLK strobes together are treated as a left-slot start.
        if (!done_channel_sync) begin
            state_d = WAIT_SYNC;
        end else begin
            case (state_q)
                WAIT_SYNC: begin
                    if (left_right_clk_rising_edge) begin
                        state_d = LEFT_TX;
                    end else if (left_right_clk_falling_edge) begin
                        state_d = RIGHT_TX;
                    end
                end
                LEFT_TX: begin
                    if (left_right_clk_falling_edge && !left_right_clk_rising_edge) begin
                        state_d = RIGHT_TX;
                    end
                end
                RIGHT_TX: begin
                    if (left_right_clk_rising_edge) begin
                        state_d = LEFT_TX;
                    end
                end
                default: state_d = WAIT_SYNC;
            endcase
        end

        load = (state_d != state_q) && (state_d != WAIT_SYNC);

        if (load) begin
            if (state_d == LEFT_TX) begin
                left_pop = ~left_empty;
                shift_d  = left_empty ? left_underrun : left_head;
            end else begin
                right_pop = ~right_empty;
                shift_d   = right_empty ? right_underrun : right_head;
            end
            bits_d = BITS_W'(AUDIO_DATA_WIDTH);
        end else if (bit_clk_falling_edge && (bits_q != '0)) begin
            shift_d = {shift_q[AUDIO_DATA_WIDTH-2:0], 1'b0};
            bits_d  = bits_q - BITS_W'(1);
        end

        // Output is registered from next-state values so the MSB appears the cycle after a load.
        serial_d = (state_d != WAIT_SYNC) && (bits_d != '0) ? shift_d[AUDIO_DATA_WIDTH-1] : 1'b0;

        left_space_d  = left_full  ? 8'd0 : 8'(FIFO_DEPTH) - 8'(left_used);
        right_space_d = right_full ? 8'd0 : 8'(FIFO_DEPTH) - 8'(right_used);
    end

    // FSM, shifter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_SYNC;
            shift_q       <= '0;
            bits_q        <= '0;
            serial_q      <= 1'b0;
            left_space_q  <= '0;
            right_space_q <= '0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bits_q        <= bits_d;
            serial_q      <= serial_d;
            left_space_q  <= left_space_d;
            right_space_q <= right_space_d;
        end
    end

    assign serial_audio_out_data        = serial_q;
    assign left_audio_fifo_write_space  = left_space_q;
    assign right_audio_fifo_write_space = right_space_q;

endmodule

// File: tb/tb_audio_out_serializer.sv
// Directed bench for audio_out_serializer: slot tables plus hand sequences
// for FIFO full, simultaneous push/pop, sync loss and mid-slot reset.
module tb_audio_out_serializer;

`ifdef AUDIO_OUT_UNDERRUN_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        brise = 1'b0, bfall = 1'b0, lrr = 1'b0, lrf = 1'b0, sync = 1'b0;
    logic        wl = 1'b0, wr = 1'b0;
    logic [31:0] ld = '0, rd = '0;
    logic [7:0]  lsp, rsp;
    logic        sdo;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    audio_out_serializer #(
        .AUDIO_DATA_WIDTH (32),
        .FIFO_DEPTH       (128),
        .FIFO_ADDR_WIDTH  (7)
    ) dut (
        .clk                          (clk),
        .reset                        (reset),
        .bit_clk_rising_edge          (brise),
        .bit_clk_falling_edge         (bfall),
        .left_right_clk_rising_edge   (lrr),
        .left_right_clk_falling_edge  (lrf),
        .done_channel_sync            (sync),
        .left_channel_data            (ld),
        .right_channel_data           (rd),
        .write_left_audio_data_en     (wl),
        .write_right_audio_data_en    (wr),
        .left_audio_fifo_write_space  (lsp),
        .right_audio_fifo_write_space (rsp),
        .serial_audio_out_data        (sdo)
    );

    typedef struct {
        bit          push_l;
        bit          push_r;
        logic [31:0] dl;
        logic [31:0] dr;
        bit          is_left;
        int          nb;
        logic [31:0] exp;
    } slot_vec_t;

    slot_vec_t   vecs [8];
    logic [31:0] simw [5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One slot of nb BCLK periods; the LRCLK strobe coincides with the first falling edge.
    task automatic run_slot(input bit is_left, input int nb, input logic [31:0] exp, input string name);
        logic [31:0] got, mask, all1;
        bit pad_bad;
        got = '0;
        pad_bad = 1'b0;
        all1 = 32'hFFFF_FFFF;
        mask = (nb >= 32) ? all1 : ~(all1 >> nb);
        for (int i = 0; i < nb; i++) begin
            brise = 1'b1;
            tick;
            brise = 1'b0;
            bfall = 1'b1;
            if (i == 0) begin
                if (is_left) lrr = 1'b1;
                else lrf = 1'b1;
            end
            tick;
            bfall = 1'b0;
            lrr = 1'b0;
            lrf = 1'b0;
            if (i < 32) got[31-i] = sdo;
            else if (sdo !== 1'b0) pad_bad = 1'b1;
        end
        check(name, got, exp & mask);
        if (nb > 32) check({name, "_pad"}, 64'(pad_bad), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 32'hA5A5_0F0F, 32'h8000_0001, 1'b1, 32, 32'hA5A5_0F0F};
        vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32, 32'h8000_0001};
        vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 34, HOLD ? 32'hA5A5_0F0F : 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 34, HOLD ? 32'h8000_0001 : 32'h0};
        vecs[4] = '{1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 32, 32'h1234_5678};
        vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 16, 32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32, HOLD ? 32'h1234_5678 : 32'h0};
        vecs[7] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 33, HOLD ? 32'hDEAD_BEEF : 32'h0};
        simw[0] = 32'hFFFF_0000;
        simw[1] = 32'h1357_9BDF;
        simw[2] = 32'h2222_2222;
        simw[3] = 32'h3333_3333;
        simw[4] = 32'h4444_4444;

        // Reset and first write-space report
        tick; tick; tick;
        check("rst_serial", 64'(sdo), 64'd0);
        check("rst_lspace", 64'(lsp), 64'd0);
        check("rst_rspace", 64'(rsp), 64'd0);
        reset = 1'b0;
        tick;
        check("post_rst_lspace", 64'(lsp), 64'd128);
        check("post_rst_rspace", 64'(rsp), 64'd128);

        // Table of slots: basic frame, underrun, truncation, padding
        sync = 1'b1;
        for (int r = 0; r < 8; r++) begin
            if (vecs[r].push_l || vecs[r].push_r) begin
                wl = vecs[r].push_l;
                wr = vecs[r].push_r;
                ld = vecs[r].dl;
                rd = vecs[r].dr;
                tick;
                wl = 1'b0;
                wr = 1'b0;
                tick;
                if (r == 0) begin
                    check("push_lspace", 64'(lsp), 64'd127);
                    check("push_rspace", 64'(rsp), 64'd127);
                end
            end
            run_slot(vecs[r].is_left, vecs[r].nb, vecs[r].exp, $sformatf("slot%0d", r));
        end
        check("frame_lspace", 64'(lsp), 64'd128);
        check("frame_rspace", 64'(rsp), 64'd128);

        // Full FIFO: 129 pushes, last one dropped, 128 play out in order
        sync = 1'b0;
        tick;
        for (int i = 0; i < 129; i++) begin
            wl = 1'b1;
            ld = 32'h1000_0000 + 32'(i);
            tick;
        end
        wl = 1'b0;
        tick;
        check("full_lspace", 64'(lsp), 64'd0);
        sync = 1'b1;
        for (int i = 0; i < 128; i++) begin
            run_slot(1'b1, 32, 32'h1000_0000 + 32'(i), $sformatf("full_l%0d", i));
            run_slot(1'b0, 4, HOLD ? 32'hDEAD_BEEF : 32'h0, $sformatf("full_r%0d", i));
        end
        run_slot(1'b1, 32, HOLD ? 32'h1000_007F : 32'h0, "full_drained");
        check("drained_lspace", 64'(lsp), 64'd128);

        // Simultaneous push and pop at 5 words
        sync = 1'b0;
        tick;
        for (int k = 0; k < 5; k++) begin
            wl = 1'b1;
            ld = simw[k];
            tick;
        end
        wl = 1'b0;
        tick;
        tick;
        check("simul_pre_space", 64'(lsp), 64'd123);
        sync = 1'b1;
        lrr = 1'b1;
        bfall = 1'b1;
        wl = 1'b1;
        ld = 32'h6666_6666;
        tick;
        lrr = 1'b0;
        bfall = 1'b0;
        wl = 1'b0;
        check("simul_msb", 64'(sdo), 64'd1);
        tick;
        check("simul_space", 64'(lsp), 64'd123);

        // Loss of sync mid-slot: output silenced next cycle, no further pops
        bfall = 1'b1; tick; bfall = 1'b0; tick;
        bfall = 1'b1; tick; bfall = 1'b0;
        check("pre_drop_bit", 64'(sdo), 64'd1);
        sync = 1'b0;
        bfall = 1'b1;
        tick;
        bfall = 1'b0;
        check("drop_out", 64'(sdo), 64'd0);
        lrr = 1'b1; tick; lrr = 1'b0;
        lrf = 1'b1; tick; lrf = 1'b0;
        lrr = 1'b1; bfall = 1'b1; tick; lrr = 1'b0; bfall = 1'b0;
        tick;
        check("drop_no_pop_space", 64'(lsp), 64'd123);
        check("drop_out_quiet", 64'(sdo), 64'd0);
        sync = 1'b1;
        run_slot(1'b1, 32, simw[1], "after_drop");
        tick;
        check("after_drop_space", 64'(lsp), 64'd124);

        // Reset mid right slot: output cleared, queued samples discarded
        rd = 32'hC000_0001;
        wr = 1'b1;
        tick;
        wr = 1'b0;
        lrf = 1'b1;
        bfall = 1'b1;
        tick;
        lrf = 1'b0;
        bfall = 1'b0;
        check("rst_pre_msb", 64'(sdo), 64'd1);
        bfall = 1'b1;
        tick;
        bfall = 1'b0;
        check("rst_pre_bit30", 64'(sdo), 64'd1);
        reset = 1'b1;
        tick;
        check("midrst_serial", 64'(sdo), 64'd0);
        check("midrst_lspace", 64'(lsp), 64'd0);
        reset = 1'b0;
        tick;
        check("midrst_post_lspace", 64'(lsp), 64'd128);
        check("midrst_post_rspace", 64'(rsp), 64'd128);
        run_slot(1'b1, 32, 32'h0, "midrst_left");
        run_slot(1'b0, 32, 32'h0, "midrst_right");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
